// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a registered one-hot grant that is held
// for as long as its owner keeps requesting.
//
// A release always costs exactly one idle cycle (grant == 0) before the next
// grant. The round-robin pointer advances only when a grant is released, and
// then points to the requester after the one just released.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   A tenure counter tracks how many consecutive cycles the owner has held the
//   grant while another requester is waiting. After MAX_HOLD such cycles the
//   owner is forced off the grant and preempt pulses for the idle cycle. A lone
//   requester is never preempted. MAX_HOLD == 0 disables the limit. Without the
//   macro there is no counter and preempt is tied to 0.
//
// Parameters:
//   NUM_REQ  - number of requesters (2..16)
//   ID_W     - width of grant_id; derived from NUM_REQ, do not override
//   MAX_HOLD - tenure limit in cycles (ARB_TIMEOUT_EN builds only), 0 = unlimited
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-low reset
//   req         in   [NUM_REQ] request vector, bit i = requester i
//   grant       out  [NUM_REQ] registered one-hot grant, 0 = idle
//   grant_valid out  registered, 1 iff grant != 0
//   grant_id    out  [ID_W] registered index of the owner, 0 when idle
//   preempt     out  registered one-cycle pulse on a timeout-forced release
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = $clog2(NUM_REQ),
    parameter int MAX_HOLD = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id,
    output logic               preempt
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_HOLD < 0 || ID_W != $clog2(NUM_REQ)) begin : g_param_check
        $error("rr_arbiter: illegal parameter combination");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state, state_nx;
    logic [ID_W-1:0]    ptr, ptr_nx;
    logic [ID_W-1:0]    id_nx;
    logic [NUM_REQ-1:0] grant_nx;

    // Round-robin pick. Scanning from the top down makes the last hit the
    // lowest index: hi_* is the first request at or above ptr, lo_* is the
    // first request overall (the wrap-around candidate).
    logic            hi_found, lo_found;
    logic [ID_W-1:0] hi_id, lo_id, pick_id;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_found = 1'b1;
                lo_id    = ID_W'(i);
                if (i >= int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_id    = ID_W'(i);
                end
            end
        end
        pick_id = hi_found ? hi_id : lo_id;
    end

    // Owner status is derived from the one-hot grant, which avoids indexing
    // req with an encoded id that may exceed NUM_REQ-1 for odd sizes.
    logic            owner_req;
    logic [ID_W-1:0] ptr_after;

    assign owner_req = |(req & grant);
    assign ptr_after = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1) + 1;

    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             preempt_nx;
    logic             competitor;

    assign competitor = |(req & ~grant);
`endif

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        id_nx    = grant_id;
        grant_nx = grant;
`ifdef ARB_TIMEOUT_EN
        cnt_nx     = cnt;
        preempt_nx = 1'b0;
`endif
        case (state)
            IDLE: begin
                grant_nx = '0;
                id_nx    = '0;
                if (lo_found) begin
                    state_nx = GRANT;
                    id_nx    = pick_id;
                    grant_nx = NUM_REQ'(1) << pick_id;
`ifdef ARB_TIMEOUT_EN
                    cnt_nx   = '0;
`endif
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                    id_nx    = '0;
                    ptr_nx   = ptr_after;
`ifdef ARB_TIMEOUT_EN
                    cnt_nx   = '0;
`endif
                end
`ifdef ARB_TIMEOUT_EN
                else if (competitor) begin
                    // Count this cycle; the release lands on the edge where the
                    // owner has completed MAX_HOLD contested cycles.
                    if (MAX_HOLD != 0 && int'(cnt) + 1 >= MAX_HOLD) begin
                        state_nx   = IDLE;
                        grant_nx   = '0;
                        id_nx      = '0;
                        ptr_nx     = ptr_after;
                        cnt_nx     = '0;
                        preempt_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end else begin
                    cnt_nx = '0;
                end
`endif
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
                id_nx    = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt         <= '0;
            preempt     <= 1'b0;
`endif
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            grant       <= grant_nx;
            grant_id    <= id_nx;
            grant_valid <= (state_nx == GRANT);
`ifdef ARB_TIMEOUT_EN
            cnt         <= cnt_nx;
            preempt     <= preempt_nx;
`endif
        end
    end

`ifndef ARB_TIMEOUT_EN
    assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (NUM_REQ=4, MAX_HOLD=4). Inputs change on the
// falling edge, outputs are sampled on the following falling edge, so each
// tick spans exactly one rising edge.
module tb_rr_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    rr_arbiter #(.NUM_REQ(4), .MAX_HOLD(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .preempt     (preempt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [3:0] eg, input logic [1:0] eid, input logic ep);
        checks++;
        assert (grant === eg) else begin
            errors++;
            $error("FAIL %s grant got %b expected %b", tag, grant, eg);
        end
        assert (grant_id === eid) else begin
            errors++;
            $error("FAIL %s grant_id got %0d expected %0d", tag, grant_id, eid);
        end
        assert (grant_valid === (eg != 4'b0000)) else begin
            errors++;
            $error("FAIL %s grant_valid got %b expected %b", tag, grant_valid, (eg != 4'b0000));
        end
        assert (preempt === ep) else begin
            errors++;
            $error("FAIL %s preempt got %b expected %b", tag, preempt, ep);
        end
    endtask

    initial begin
        // Reset held two cycles while everyone requests.
        reset = 1'b0;
        req   = 4'b1111;
        tick(); tick();
        check("reset", 4'b0000, 2'd0, 1'b0);

        // First grant goes to requester 0 (ptr=0) and is held.
        reset = 1'b1;
        tick(); check("first_grant", 4'b0001, 2'd0, 1'b0);
        tick(); check("hold0", 4'b0001, 2'd0, 1'b0);

        // Owner drops: one idle cycle, then the next in rotation.
        req = 4'b1110;
        tick(); check("rel0_idle", 4'b0000, 2'd0, 1'b0);
        tick(); check("grant1", 4'b0010, 2'd1, 1'b0);
        tick(); check("hold1", 4'b0010, 2'd1, 1'b0);

        req = 4'b1100;
        tick(); check("rel1_idle", 4'b0000, 2'd0, 1'b0);
        tick(); check("grant2", 4'b0100, 2'd2, 1'b0);

        // Release 2 -> ptr=3; requester 3 wins over 0, then wrap to 0.
        req = 4'b1001;
        tick(); check("rel2_idle", 4'b0000, 2'd0, 1'b0);
        tick(); check("grant3_ptr", 4'b1000, 2'd3, 1'b0);
        req = 4'b0001;
        tick(); check("rel3_idle", 4'b0000, 2'd0, 1'b0);
        tick(); check("wrap_grant0", 4'b0001, 2'd0, 1'b0);
        req = 4'b0000;
        tick(); check("rel_wrap_idle", 4'b0000, 2'd0, 1'b0);
        tick(); check("stay_idle", 4'b0000, 2'd0, 1'b0);

        // Single far requester straight out of reset.
        reset = 1'b0;
        tick(); check("reset2", 4'b0000, 2'd0, 1'b0);
        reset = 1'b1;
        req   = 4'b1000;
        tick(); check("far_grant3", 4'b1000, 2'd3, 1'b0);
        req = 4'b0000;
        tick(); check("far_release", 4'b0000, 2'd0, 1'b0);
        tick(); check("far_idle", 4'b0000, 2'd0, 1'b0);

        // ptr is 0 again (released 3). Reset in the middle of a held grant.
        req = 4'b0100;
        tick(); check("mid_grant2", 4'b0100, 2'd2, 1'b0);
        reset = 1'b0;
        tick(); check("mid_reset", 4'b0000, 2'd0, 1'b0);
        reset = 1'b1;
        req   = 4'b0101;
        tick(); check("post_reset_ptr0", 4'b0001, 2'd0, 1'b0);

        // Non-owner requests toggle without effect.
        req = 4'b0111;
        tick(); check("toggle_a", 4'b0001, 2'd0, 1'b0);
        req = 4'b1011;
        tick(); check("toggle_b", 4'b0001, 2'd0, 1'b0);
        req = 4'b0000;
        tick(); check("toggle_rel", 4'b0000, 2'd0, 1'b0);
        tick(); check("toggle_idle", 4'b0000, 2'd0, 1'b0);

        // Contested hold with req=0011 from ptr=0.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        req   = 4'b0011;
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            tick(); check("to_hold0", 4'b0001, 2'd0, 1'b0);
        end
        tick(); check("to_preempt0", 4'b0000, 2'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick(); check("to_hold1", 4'b0010, 2'd1, 1'b0);
        end
        tick(); check("to_preempt1", 4'b0000, 2'd0, 1'b1);
        tick(); check("to_back0", 4'b0001, 2'd0, 1'b0);
`else
        for (int k = 0; k < 12; k++) begin
            tick(); check("no_timeout_hold", 4'b0001, 2'd0, 1'b0);
        end
`endif

        // A lone requester is never preempted.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        req   = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            tick(); check("lone_hold", 4'b0001, 2'd0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Parametrised round-robin arbiter; successor to the 2-requester fixed-priority grant-hold arbiter.
- Arbitrates NUM_REQ requesters for one shared resource; grant is registered, one-hot, and held while the owner keeps requesting.
- Keeps the existing one-idle-cycle handover convention. Adds rotating fairness, an encoded grant id, and optional tenure-limit preemption.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(NUM_REQ), width of grant_id (derived; do not override).
- MAX_HOLD, 8, max consecutive grant cycles before preemption; used only with ARB_TIMEOUT_EN; 0 = unlimited.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous active-low reset (0 = reset, sampled on rising clock).
- req  input  NUM_REQ  request vector; bit i = requester i.
- grant  output  NUM_REQ  registered one-hot grant; all-zero = idle.
- grant_valid  output  1  registered; 1 iff grant != 0.
- grant_id  output  ID_W  registered index of granted requester; 0 when idle.
- preempt  output  1  registered one-cycle pulse marking a timeout-forced release (tied 0 without ARB_TIMEOUT_EN).

Behaviour:
- Reset (reset==0 at rising edge): grant=0, grant_valid=0, grant_id=0, preempt=0, state=IDLE, priority pointer ptr=0, hold counter=0. Reset has priority over all other events, including mid-grant (grant drops to 0 at that edge).
- FSM states:
  - IDLE: if req!=0, the next edge enters GRANT to the first set req bit searching ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1 (wrap-around). If req==0, stay in IDLE.
  - GRANT(i):
    - req[i]==1: hold grant i; other requests are ignored.
    - req[i]==0: next edge → IDLE with grant=0, ptr=(i+1) mod NUM_REQ.
- Latency:
  - req sampled at edge N → grant visible after edge N.
  - Release always inserts exactly one idle cycle (grant=0) before any new grant, even if others are requesting.
- ptr updates only on leaving GRANT; it never changes in IDLE.
- At most one grant bit is ever set. grant_id and grant_valid are always consistent with grant.
- Requests for non-owners may toggle freely without effect while GRANT is held.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Hold counter counts consecutive cycles in GRANT(i) while any other req bit is set; it resets to 0 on entering GRANT or when no competitor is requesting.
  - When the counter reaches MAX_HOLD (MAX_HOLD!=0), the next edge forces IDLE (grant=0), pulses preempt=1 for that cycle, and sets ptr=(i+1) mod NUM_REQ even if req[i] is still 1.
  - A lone requester is never preempted.
- Not defined: no counter logic; owner holds indefinitely; preempt tied to 0.

Test Plan (NUM_REQ=4, MAX_HOLD=4):
- Reset low for 2 cycles with req=1111 → grant=0000, grant_id=0; release reset, req=1111 → grant=0001, grant_id=0 one edge later, held while req[0]=1.
- Owner drops: req 1111→1110 → one cycle grant=0000, then grant=0010 (grant_id=1); req 1110→1100 → 0000, then 0100.
- Rotation/wrap: ptr=3 after releasing requester 2, req=1001 → grant=1000; drop req[3] → 0000, then 0001.
- Single far requester from reset: req=1000 → grant=1000, grant_id=3; req=0000 → grant=0000, stays idle.
- Reset mid-operation: grant=0100 held, reset=0 for one edge → grant=0000, ptr=0; release with req=0101 → grant=0001.
- Timeout: req=0011 held constant.
  - With ARB_TIMEOUT_EN: 0001 for 4 cycles, then 0000 with preempt=1, then 0010 for 4 cycles, 0000/preempt, 0001 …
  - Without the macro: grant stays 0001 indefinitely, preempt=0.
